regfile_wb_ctrl: RTL and testbench

// - Writer side of the register-file write port: sole driver of rg_wrt_en/rg_wrt_dest/rg_wrt_data.
// - Merges single-cycle ALU results with variable-latency data-memory load responses.
// - Tracks outstanding loads in order; performs load byte-lane select and sign/zero extension.
// - Exports a per-register load-busy scoreboard for decode hazard stalls.

---
 rtl/rv_wb_pkg.sv | 50 +++++
 rtl/wb_meta_fifo.sv | 69 ++++++
 rtl/regfile_wb_ctrl.sv | 147 ++++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rv_wb_pkg.sv
// Shared types for the register-file writeback path: load funct3 codes,
// outstanding-load metadata and the load byte-lane extraction/extension function.
package rv_wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0] dest;
        logic [2:0] funct3;
        logic [1:0] offset;
    } wb_meta_t;

    function automatic logic funct3_is_load(input logic [2:0] funct3);
        logic ok;
        case (funct3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Unknown funct3 codes fall through to a full-word pass so the write still retires.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  offset);
        logic [7:0]  byte_s;
        logic [15:0] half_s;
        logic [31:0] res;
        case (offset)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            default: byte_s = word[31:24];
        endcase
        half_s = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   res = {{24{byte_s[7]}}, byte_s};
            F3_LBU:  res = {24'h00_0000, byte_s};
            F3_LH:   res = {{16{half_s[15]}}, half_s};
            F3_LHU:  res = {16'h0000, half_s};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_meta_fifo.sv
// In-order FIFO of outstanding-load metadata; the head is the load the next
// memory response belongs to.
module wb_meta_fifo
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  wb_meta_t din,
    output wb_meta_t dout,
    output logic     full,
    output logic     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    wb_meta_t      mem_q [DEPTH];
    wb_meta_t      mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    // Next-state pointers, occupancy and storage.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-port owner: arbitrates ALU results against in-order load
// responses (ALU first, losing load parked in a one-entry hold) and keeps a load-busy scoreboard.
module regfile_wb_ctrl
    import rv_wb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_REGS      = 32,
    parameter int LD_DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_wb_valid,
    input  logic [ADDRESS_WIDTH-1:0] alu_wb_dest,
    input  logic [DATA_WIDTH-1:0]    alu_wb_data,
    input  logic                     ld_req_valid,
    output logic                     ld_req_ready,
    input  logic [ADDRESS_WIDTH-1:0] ld_req_dest,
    input  logic [2:0]               ld_req_funct3,
    input  logic [1:0]               ld_req_offset,
    input  logic                     mem_rsp_valid,
    output logic                     mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0]    mem_rsp_data,
    output logic                     rg_wrt_en,
    output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
    output logic [DATA_WIDTH-1:0]    rg_wrt_data,
    output logic [NUM_REGS-1:0]      ld_busy,
    output logic                     ld_err
);

    logic                     rg_wrt_en_q, rg_wrt_en_d;
    logic [ADDRESS_WIDTH-1:0] rg_wrt_dest_q, rg_wrt_dest_d;
    logic [DATA_WIDTH-1:0]    rg_wrt_data_q, rg_wrt_data_d;
    logic [NUM_REGS-1:0]      ld_busy_q, ld_busy_d;
    logic                     ld_err_q, ld_err_d;
    logic                     hold_valid_q, hold_valid_d;
    logic [ADDRESS_WIDTH-1:0] hold_dest_q, hold_dest_d;
    logic [DATA_WIDTH-1:0]    hold_data_q, hold_data_d;

    wb_meta_t fifo_din_s, fifo_dout_s;
    logic     fifo_full_s, fifo_empty_s;
    logic     ld_acc_s, rsp_acc_s, rsp_pop_s, orphan_s, bad_f3_s;
    logic     cand_valid_s;
    logic [ADDRESS_WIDTH-1:0] cand_dest_s;
    logic [DATA_WIDTH-1:0]    cand_data_s;

    assign ld_req_ready  = !fifo_full_s && !ld_busy_q[ld_req_dest];
    assign mem_rsp_ready = !hold_valid_q;
    assign ld_acc_s      = ld_req_valid && ld_req_ready;
    assign rsp_acc_s     = mem_rsp_valid && mem_rsp_ready;
    assign rsp_pop_s     = rsp_acc_s && !fifo_empty_s;
    assign orphan_s      = rsp_acc_s && fifo_empty_s;
    assign bad_f3_s      = rsp_pop_s && !funct3_is_load(fifo_dout_s.funct3);
    assign fifo_din_s    = '{dest: ld_req_dest, funct3: ld_req_funct3, offset: ld_req_offset};

    // The hold entry is older than any new response, and blocks new ones while full.
    assign cand_valid_s = hold_valid_q || rsp_pop_s;
    assign cand_dest_s  = hold_valid_q ? hold_dest_q : fifo_dout_s.dest;
    assign cand_data_s  = hold_valid_q ? hold_data_q
                        : load_extend(mem_rsp_data, fifo_dout_s.funct3, fifo_dout_s.offset);

    wb_meta_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ld_acc_s),
        .pop   (rsp_pop_s),
        .din   (fifo_din_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Write-port arbitration, hold-register parking and scoreboard update.
    always_comb begin
        rg_wrt_en_d   = 1'b0;
        rg_wrt_dest_d = rg_wrt_dest_q;
        rg_wrt_data_d = rg_wrt_data_q;
        hold_valid_d  = hold_valid_q;
        hold_dest_d   = hold_dest_q;
        hold_data_d   = hold_data_q;
        ld_busy_d     = ld_busy_q;
        ld_err_d      = orphan_s || bad_f3_s;
        if (alu_wb_valid) begin
            rg_wrt_en_d = (alu_wb_dest != '0);
            if (alu_wb_dest != '0) begin
                rg_wrt_dest_d = alu_wb_dest;
                rg_wrt_data_d = alu_wb_data;
            end else begin
                rg_wrt_dest_d = rg_wrt_dest_q;
            end
            if (cand_valid_s) begin
                hold_valid_d = 1'b1;
                hold_dest_d  = cand_dest_s;
                hold_data_d  = cand_data_s;
            end else begin
                hold_valid_d = hold_valid_q;
            end
        end else if (cand_valid_s) begin
            rg_wrt_en_d  = (cand_dest_s != '0);
            if (cand_dest_s != '0) begin
                rg_wrt_dest_d = cand_dest_s;
                rg_wrt_data_d = cand_data_s;
            end else begin
                rg_wrt_dest_d = rg_wrt_dest_q;
            end
            hold_valid_d = 1'b0;
            ld_busy_d[cand_dest_s] = 1'b0;
        end else begin
            rg_wrt_en_d = 1'b0;
        end
        if (ld_acc_s && (ld_req_dest != '0)) begin
            ld_busy_d[ld_req_dest] = 1'b1;
        end else begin
            ld_err_d = ld_err_d;
        end
    end

    // Registered write port, scoreboard, error pulse and hold entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rg_wrt_en_q   <= 1'b0;
            rg_wrt_dest_q <= '0;
            rg_wrt_data_q <= '0;
            ld_busy_q     <= '0;
            ld_err_q      <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_dest_q   <= '0;
            hold_data_q   <= '0;
        end else begin
            rg_wrt_en_q   <= rg_wrt_en_d;
            rg_wrt_dest_q <= rg_wrt_dest_d;
            rg_wrt_data_q <= rg_wrt_data_d;
            ld_busy_q     <= ld_busy_d;
            ld_err_q      <= ld_err_d;
            hold_valid_q  <= hold_valid_d;
            hold_dest_q   <= hold_dest_d;
            hold_data_q   <= hold_data_d;
        end
    end

    assign rg_wrt_en   = rg_wrt_en_q;
    assign rg_wrt_dest = rg_wrt_dest_q;
    assign rg_wrt_data = rg_wrt_data_q;
    assign ld_busy     = ld_busy_q;
    assign ld_err      = ld_err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl: load extension, ALU/load
// conflict, FIFO full stall, x0 loads, orphan responses and mid-stream reset.
module tb_regfile_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_dest;
    logic [31:0] alu_wb_data;
    logic        ld_req_valid;
    logic        ld_req_ready;
    logic [4:0]  ld_req_dest;
    logic [2:0]  ld_req_funct3;
    logic [1:0]  ld_req_offset;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_data;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_dest;
    logic [31:0] rg_wrt_data;
    logic [31:0] ld_busy;
    logic        ld_err;

    int errors = 0;
    int checks = 0;

    regfile_wb_ctrl dut (
        .clk(clk), .rst(rst),
        .alu_wb_valid(alu_wb_valid), .alu_wb_dest(alu_wb_dest), .alu_wb_data(alu_wb_data),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_dest(ld_req_dest),
        .ld_req_funct3(ld_req_funct3), .ld_req_offset(ld_req_offset),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
        .rg_wrt_en(rg_wrt_en), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data),
        .ld_busy(ld_busy), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_wb_valid  = 1'b0; alu_wb_dest = 5'd0; alu_wb_data = 32'h0;
        ld_req_valid  = 1'b0; ld_req_dest = 5'd0; ld_req_funct3 = 3'b010; ld_req_offset = 2'd0;
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    endtask

    task automatic send_req(input logic [4:0] d, input logic [2:0] f3, input logic [1:0] off);
        ld_req_valid = 1'b1; ld_req_dest = d; ld_req_funct3 = f3; ld_req_offset = off;
        tick();
        ld_req_valid = 1'b0;
    endtask

    task automatic send_rsp(input logic [31:0] w);
        mem_rsp_valid = 1'b1; mem_rsp_data = w;
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick(); tick();
        checks++; if ({rg_wrt_en, rg_wrt_dest, rg_wrt_data} !== 38'h0) begin errors++;
            $display("FAIL reset_wrt: got en=%b dest=%0d data=%h required 0", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        checks++; if (ld_busy !== 32'h0 || ld_err !== 1'b0) begin errors++;
            $display("FAIL reset_busy_err: got busy=%h err=%b required 0/0", ld_busy, ld_err); end
        rst = 1'b0;
        #1;
        checks++; if (ld_req_ready !== 1'b1 || mem_rsp_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready: got req=%b rsp=%b required 1/1", ld_req_ready, mem_rsp_ready); end
    endtask

    task automatic test_lb_sign();
        send_req(5'd5, 3'b000, 2'd2);
        checks++; if (ld_busy !== 32'h0000_0020 || rg_wrt_en !== 1'b0) begin errors++;
            $display("FAIL lb_busy_set: got busy=%h en=%b required 00000020/0", ld_busy, rg_wrt_en); end
        send_rsp(32'h1280_3456);
        checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd5 || rg_wrt_data !== 32'hFFFF_FF80) begin errors++;
            $display("FAIL lb_write: got en=%b dest=%0d data=%h required 1/5/ffffff80", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        checks++; if (ld_busy !== 32'h0) begin errors++;
            $display("FAIL lb_busy_clr: got %h required 0", ld_busy); end
        tick();
        checks++; if (rg_wrt_en !== 1'b0 || rg_wrt_data !== 32'hFFFF_FF80) begin errors++;
            $display("FAIL idle_hold: got en=%b data=%h required 0/ffffff80", rg_wrt_en, rg_wrt_data); end
    endtask

    task automatic test_half();
        send_req(5'd6, 3'b101, 2'd3);
        send_rsp(32'h8001_0000);
        checks++; if (rg_wrt_dest !== 5'd6 || rg_wrt_data !== 32'h0000_8001) begin errors++;
            $display("FAIL lhu: got dest=%0d data=%h required 6/00008001", rg_wrt_dest, rg_wrt_data); end
        send_req(5'd6, 3'b001, 2'd3);
        send_rsp(32'h8001_0000);
        checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_data !== 32'hFFFF_8001) begin errors++;
            $display("FAIL lh: got en=%b data=%h required 1/ffff8001", rg_wrt_en, rg_wrt_data); end
        send_req(5'd9, 3'b100, 2'd1);
        send_rsp(32'h1280_3456);
        checks++; if (rg_wrt_data !== 32'h0000_0034) begin errors++;
            $display("FAIL lbu: got %h required 00000034", rg_wrt_data); end
    endtask

    task automatic test_conflict();
        send_req(5'd8, 3'b010, 2'd0);
        alu_wb_valid = 1'b1; alu_wb_dest = 5'd7; alu_wb_data = 32'hA;
        send_rsp(32'hCAFE_BABE);
        alu_wb_valid = 1'b0;
        checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd7 || rg_wrt_data !== 32'hA) begin errors++;
            $display("FAIL conflict_alu: got en=%b dest=%0d data=%h required 1/7/0000000a", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        checks++; if (mem_rsp_ready !== 1'b0 || ld_busy !== 32'h0000_0100) begin errors++;
            $display("FAIL conflict_hold: got rsp_ready=%b busy=%h required 0/00000100", mem_rsp_ready, ld_busy); end
        tick();
        checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'd8 || rg_wrt_data !== 32'hCAFE_BABE) begin errors++;
            $display("FAIL conflict_load: got en=%b dest=%0d data=%h required 1/8/cafebabe", rg_wrt_en, rg_wrt_dest, rg_wrt_data); end
        checks++; if (mem_rsp_ready !== 1'b1 || ld_busy !== 32'h0) begin errors++;
            $display("FAIL conflict_drain: got rsp_ready=%b busy=%h required 1/0", mem_rsp_ready, ld_busy); end
    endtask

    task automatic test_fifo_full();
        for (int i = 1; i <= 4; i++) send_req(5'(i), 3'b010, 2'd0);
        checks++; if (ld_busy !== 32'h0000_001E) begin errors++;
            $display("FAIL full_busy: got %h required 0000001e", ld_busy); end
        ld_req_valid = 1'b1; ld_req_dest = 5'd10; ld_req_funct3 = 3'b010;
        #1;
        checks++; if (ld_req_ready !== 1'b0) begin errors++;
            $display("FAIL full_stall: got ready=%b required 0", ld_req_ready); end
        send_rsp(32'd1);
        ld_req_valid = 1'b1;
        #1;
        checks++; if (ld_req_ready !== 1'b1 || rg_wrt_dest !== 5'd1 || rg_wrt_data !== 32'd1) begin errors++;
            $display("FAIL full_pop1: got ready=%b dest=%0d data=%h required 1/1/1", ld_req_ready, rg_wrt_dest, rg_wrt_data); end
        ld_req_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            send_rsp(32'(i * 16));
            checks++; if (rg_wrt_en !== 1'b1 || rg_wrt_dest !== 5'(i) || rg_wrt_data !== 32'(i * 16)) begin errors++;
                $display("FAIL full_pop%0d: got en=%b dest=%0d data=%h required 1/%0d/%h", i, rg_wrt_en, rg_wrt_dest, rg_wrt_data, i, i * 16); end
        end
        checks++; if (ld_busy !== 32'h0) begin errors++;
            $display("FAIL full_busy_clr: got %h required 0", ld_busy); end
    endtask

    task automatic test_x0_orphan();
        send_req(5'd0, 3'b010, 2'd0);
        checks++; if (ld_busy !== 32'h0) begin errors++;
            $display("FAIL x0_busy: got %h required 0", ld_busy); end
        send_rsp(32'hFFFF_FFFF);
        checks++; if (rg_wrt_en !== 1'b0 || ld_err !== 1'b0) begin errors++;
            $display("FAIL x0_write: got en=%b err=%b required 0/0", rg_wrt_en, ld_err); end
        send_rsp(32'h1234_5678);
        checks++; if (ld_err !== 1'b1 || rg_wrt_en !== 1'b0) begin errors++;
            $display("FAIL orphan_err: got err=%b en=%b required 1/0", ld_err, rg_wrt_en); end
        tick();
        checks++; if (ld_err !== 1'b0) begin errors++;
            $display("FAIL orphan_pulse: got err=%b required 0", ld_err); end
    endtask

    task automatic test_bad_funct3();
        send_req(5'd13, 3'b011, 2'd1);
        send_rsp(32'h1122_3344);
        checks++; if (rg_wrt_dest !== 5'd13 || rg_wrt_data !== 32'h1122_3344 || ld_err !== 1'b1) begin errors++;
            $display("FAIL bad_f3: got dest=%0d data=%h err=%b required 13/11223344/1", rg_wrt_dest, rg_wrt_data, ld_err); end
    endtask

    task automatic test_reset_mid();
        send_req(5'd10, 3'b010, 2'd0);
        send_req(5'd11, 3'b010, 2'd0);
        alu_wb_valid = 1'b1; alu_wb_dest = 5'd12; alu_wb_data = 32'h5;
        tick();
        alu_wb_valid = 1'b0;
        checks++; if (rg_wrt_en !== 1'b1 || ld_busy !== 32'h0000_0C00) begin errors++;
            $display("FAIL pre_rst: got en=%b busy=%h required 1/00000c00", rg_wrt_en, ld_busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({rg_wrt_en, rg_wrt_dest, rg_wrt_data} !== 38'h0 || ld_busy !== 32'h0) begin errors++;
            $display("FAIL mid_rst: got en=%b dest=%0d data=%h busy=%h required all 0", rg_wrt_en, rg_wrt_dest, rg_wrt_data, ld_busy); end
        tick();
        rst = 1'b0;
        send_rsp(32'hDEAD_BEEF);
        checks++; if (ld_err !== 1'b1 || rg_wrt_en !== 1'b0) begin errors++;
            $display("FAIL post_rst_orphan: got err=%b en=%b required 1/0", ld_err, rg_wrt_en); end
    endtask

    initial begin
        test_reset();
        test_lb_sign();
        test_half();
        test_conflict();
        test_fifo_full();
        test_x0_orphan();
        test_bad_funct3();
        test_reset_mid();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
